// File: rtl/seq_trig_pkg.sv
// seq_trig_pkg: shared constants and helpers for the sequence trigger
package seq_trig_pkg;
  localparam logic [127:0] AES_PT_VEC = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] AES_KEY_VEC = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] ZERO_VEC = 128'h0;
  localparam logic [127:0] ONE_VEC = 128'h1;
  localparam int STRICT_RESTART = 1;
  localparam int HOLD = 0;
  function automatic int stage_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/seq_trig_timeout.sv
// seq_trig_timeout: inter-stage watchdog; expired when TIMEOUT-1 idle cycles elapse while running
module seq_trig_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
  // count idle cycles; restart on any stage progress or whenever not running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || !run) ? '0 : cnt + 1'b1;
  assign expired = run && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/seq_pattern_trigger.sv
// seq_pattern_trigger: in-order multi-pattern detector with sticky trigger; timeout enabled by SEQ_TRIG_TIMEOUT_EN
module seq_pattern_trigger import seq_trig_pkg::*; #(
  parameter int DATA_W = 128,
  parameter int NUM_STAGES = 4,
  parameter logic [NUM_STAGES*DATA_W-1:0] PATTERNS = {ONE_VEC, ZERO_VEC, AES_PT_VEC, AES_KEY_VEC},
  parameter int STRICT = STRICT_RESTART,
  parameter int CNT_W = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             arm,
  input  logic                             trig_clr,
  input  logic                             data_valid,
  input  logic [DATA_W-1:0]                data,
  output logic                             trig,
  output logic                             trig_pulse,
  output logic [stage_w(NUM_STAGES)-1:0]   stage,
  output logic [CNT_W-1:0]                 hit_count
);
  localparam int SW = stage_w(NUM_STAGES);
  localparam logic [SW-1:0] LAST = SW'(NUM_STAGES);
  localparam bit STR = STRICT != HOLD;
  logic [DATA_W-1:0] cur_pat;
  logic [SW-1:0] adv_stage, stage_nx;
  logic sample, hit, seed, prog, done, expired;
  // select the pattern for the current stage and work out where this word takes us
  always_comb begin
    cur_pat = PATTERNS[DATA_W-1:0];
    for (int k = 1; k < NUM_STAGES; k++)
      if (stage == SW'(k)) cur_pat = PATTERNS[k*DATA_W +: DATA_W];
    sample = arm && data_valid && !trig;
    hit = data == cur_pat;
    seed = data == PATTERNS[DATA_W-1:0];
    adv_stage = hit ? stage + 1'b1 : (STR && seed) ? SW'(1) : STR ? '0 : stage;
    prog = sample && (hit || (STR && seed));
    done = sample && (adv_stage == LAST);
    stage_nx = prog ? adv_stage : expired ? '0 : sample ? adv_stage : stage;
  end
`ifdef SEQ_TRIG_TIMEOUT_EN
  seq_trig_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .run(stage != '0 && stage != LAST && !trig),
    .clr(trig_clr || prog),
    .expired(expired)
  );
`else
  assign expired = 1'b0 & (TIMEOUT > 0);
`endif
  // progress, sticky trigger, completion strobe and saturating hit counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trig <= 1'b0;
      trig_pulse <= 1'b0;
      stage <= '0;
      hit_count <= '0;
    end else if (trig_clr) begin
      trig <= 1'b0;
      trig_pulse <= 1'b0;
      stage <= '0;
    end else begin
      trig <= trig || done;
      trig_pulse <= done;
      stage <= stage_nx;
      if (done && !(&hit_count)) hit_count <= hit_count + 1'b1;
    end
endmodule

// File: tb/tb_seq_pattern_trigger.sv
// tb_seq_pattern_trigger: directed self-checking bench for seq_pattern_trigger
module tb_seq_pattern_trigger;
  localparam logic [127:0] P0 = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] P1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] P2 = 128'h0;
  localparam logic [127:0] P3 = 128'h1;
  localparam logic [127:0] BAD = 128'hdead;
  localparam logic [127:0] ONE_PAT = 128'h5a;
  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b1, trig_clr = 1'b0, data_valid = 1'b0;
  logic [127:0] data = '0;
  logic trig0, pulse0, trig_h, pulse_h, trig_o, pulse_o, trig_t, pulse_t;
  logic [2:0] stage0, stage_h, stage_t;
  logic [0:0] stage_o;
  logic [7:0] hit0, hit_h, hit_o, hit_t;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  seq_pattern_trigger u0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_clr(trig_clr), .data_valid(data_valid), .data(data),
    .trig(trig0), .trig_pulse(pulse0), .stage(stage0), .hit_count(hit0));
  seq_pattern_trigger #(.STRICT(0)) u_h (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_clr(trig_clr), .data_valid(data_valid), .data(data),
    .trig(trig_h), .trig_pulse(pulse_h), .stage(stage_h), .hit_count(hit_h));
  seq_pattern_trigger #(.NUM_STAGES(1), .PATTERNS(ONE_PAT)) u_one (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_clr(trig_clr), .data_valid(data_valid), .data(data),
    .trig(trig_o), .trig_pulse(pulse_o), .stage(stage_o), .hit_count(hit_o));
  seq_pattern_trigger #(.TIMEOUT(8)) u_to (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_clr(trig_clr), .data_valid(data_valid), .data(data),
    .trig(trig_t), .trig_pulse(pulse_t), .stage(stage_t), .hit_count(hit_t));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [127:0] d);
    data_valid = v;
    data = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [2:0] to_exp;
`ifdef SEQ_TRIG_TIMEOUT_EN
    to_exp = 3'd0;
`else
    to_exp = 3'd1;
`endif
    #12;
    chk("rst_trig", trig0, 0);
    chk("rst_pulse", pulse0, 0);
    chk("rst_stage", stage0, 0);
    chk("rst_hit", hit0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, P0); chk("seq_s1", stage0, 1);
    step(1, P1); chk("seq_s2", stage0, 2);
    step(1, P2); chk("seq_s3", stage0, 3); chk("seq_notrig", trig0, 0);
    step(1, P3);
    chk("seq_s4", stage0, 4); chk("seq_trig", trig0, 1); chk("seq_pulse", pulse0, 1); chk("seq_hit", hit0, 1);
    chk("hold_trig", trig_h, 1);
    step(0, 0); chk("pulse_low", pulse0, 0); chk("trig_sticky", trig0, 1);
    step(1, P0); chk("sticky_stage", stage0, 4); chk("sticky_hit", hit0, 1); chk("sticky_pulse", pulse0, 0);
    trig_clr = 1'b1; step(0, 0); trig_clr = 1'b0;
    chk("clr_trig", trig0, 0); chk("clr_stage", stage0, 0); chk("clr_hit", hit0, 1);
    step(1, P0); step(1, P1); chk("strict_s2", stage0, 2); chk("lenient_s2", stage_h, 2);
    step(1, BAD); chk("strict_restart", stage0, 0); chk("lenient_hold", stage_h, 2);
    step(1, P0); chk("strict_seed", stage0, 1); chk("lenient_hold2", stage_h, 2);
    step(1, P0); chk("strict_reseed", stage0, 1); chk("lenient_hold3", stage_h, 2);
    trig_clr = 1'b1; step(0, 0); trig_clr = 1'b0;
    step(0, P0); step(0, P1); step(0, P2); step(0, P3);
    chk("novalid_stage", stage0, 0); chk("novalid_trig", trig0, 0);
    arm = 1'b0;
    step(1, P0); step(1, P1); step(1, P2); step(1, P3);
    chk("noarm_stage", stage0, 0); chk("noarm_trig", trig0, 0);
    arm = 1'b1; step(1, P0); step(1, P1);
    arm = 1'b0; step(1, P2); step(1, P3); chk("arm_freeze", stage0, 2);
    arm = 1'b1; step(1, P2); chk("arm_resume", stage0, 3);
    step(1, P3); chk("arm_trig", trig0, 1); chk("arm_hit", hit0, 2);
    trig_clr = 1'b1; step(0, 0); trig_clr = 1'b0;
    step(1, P0); step(1, P1); step(1, P2);
    trig_clr = 1'b1; step(1, P3); trig_clr = 1'b0;
    chk("clrpri_trig", trig0, 0); chk("clrpri_stage", stage0, 0); chk("clrpri_pulse", pulse0, 0);
    chk("clrpri_hit", hit0, 2);
    step(1, P0); step(1, P1); step(1, P2); chk("async_pre", stage0, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("async_trig", trig0, 0); chk("async_pulse", pulse0, 0);
    chk("async_stage", stage0, 0); chk("async_hit", hit0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, ONE_PAT);
    chk("one_trig", trig_o, 1); chk("one_stage", stage_o, 1); chk("one_pulse", pulse_o, 1);
    chk("one_hit", hit_o, 1); chk("one_main_idle", stage0, 0);
    trig_clr = 1'b1; step(0, 0); trig_clr = 1'b0;
    step(1, P0);
    for (int i = 0; i < 7; i++) step(0, 0);
    chk("to_7idle", stage_t, 1);
    step(0, 0); chk("to_8idle", stage_t, to_exp);
    trig_clr = 1'b1; step(0, 0); trig_clr = 1'b0;
    step(1, P0);
    for (int i = 0; i < 7; i++) step(0, 0);
    step(1, P1); chk("to_advance", stage_t, 2);
    trig_clr = 1'b1; step(0, 0); trig_clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step(1, P0); step(1, P1); step(1, P2); step(1, P3);
      if (i == 0) chk("sat_first", hit0, 1);
      if (i == 254) chk("sat_255", hit0, 255);
      trig_clr = 1'b1; step(0, 0); trig_clr = 1'b0;
    end
    chk("sat_hold", hit0, 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_pattern_trigger.md
Name: seq_pattern_trigger

Overview:
- Parametrised, clocked multi-stage sequence detector. It watches a datapath word, such as the AES round state, and raises a trigger after NUM_STAGES programmed patterns appear in order.
- Successor to the combinational-latch trigger. Adds: clock and async reset, a valid qualifier, arm and clear controls, a strict or lenient mismatch policy, a one-cycle pulse, a saturating hit counter and an optional inter-stage timeout.
- Sits beside the cipher core. Its output feeds payload logic.

Parameters:
- DATA_W, 128, width of the observed word.
- NUM_STAGES, 4, number of patterns in the sequence (1..16).
- PATTERNS, {128'h1, 128'h0, 128'h00112233_44556677_8899aabb_ccddeeff, 128'h3243f6a8_885a308d_313198a2_e0370734}, packed NUM_STAGES*DATA_W bits. Stage k's pattern is slice [k*DATA_W +: DATA_W]; stage 0 is the least-significant slice.
- STRICT, 1, mismatch policy: 1 = restart on mismatch, 0 = hold progress.
- CNT_W, 8, hit counter width.
- TIMEOUT, 1024, maximum cycles between consecutive stage matches (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  detection enable; when 0, data_valid is ignored.
- trig_clr  in  1  synchronous clear of trig, stage and timeout.
- data_valid  in  1  data qualifier.
- data  in  DATA_W  observed word.
- trig  out  1  sticky trigger.
- trig_pulse  out  1  one-cycle completion strobe.
- stage  out  $clog2(NUM_STAGES+1)  current progress, 0..NUM_STAGES.
- hit_count  out  CNT_W  saturating count of completions.

Behaviour:
- Reset: asynchronous, active-low on rst_n, single clock clk. While rst_n=0, all of the following are 0: trig, trig_pulse, stage, hit_count, timeout counter.
- Sampling: a word is evaluated only on a clk edge with arm=1, data_valid=1 and trig=0. No other edge changes stage, except trig_clr and timeout.
- Match (data == PATTERNS[stage]):
  - stage increments.
  - If the new stage equals NUM_STAGES: trig=1 and trig_pulse=1 on that edge (latency 1 cycle from the final matching word); hit_count increments, saturating at all-ones.
- Mismatch, STRICT=1: stage <= (data==PATTERNS[0]) ? 1 : 0. The word may re-seed the sequence. If NUM_STAGES=1, that re-seed is a completion.
- Mismatch, STRICT=0: stage holds.
- Once trig=1: sticky. stage holds at NUM_STAGES and further words are ignored until trig_clr.
- trig_pulse: high for exactly one cycle per completion.
- trig_clr=1: next edge forces trig=0, stage=0 and timeout=0. It has priority over a simultaneous completing match; that match is discarded and trig_pulse stays 0. hit_count is not cleared.
- arm deassertion mid-sequence: stage freezes and is not cleared.
- Identical consecutive patterns are legal. Each occurrence needs its own valid word.
- NUM_STAGES=1: the first matching word triggers.

Optional Feature:
- Macro: SEQ_TRIG_TIMEOUT_EN.
- With the macro:
  - A counter runs while 0 < stage < NUM_STAGES and trig=0.
  - It reloads to 0 on every stage advance.
  - When it reaches TIMEOUT-1 without an advance, the next edge sets stage=0 and counter=0.
  - If a match occurs on that same edge, the match wins.
- Without the macro: no counter; progress persists indefinitely.

Decomposition:
- Package seq_trig_pkg holds:
  - function stage_w(n) returning $clog2(n+1);
  - the default AES pattern constants AES_PT_VEC, AES_KEY_VEC, ZERO_VEC and ONE_VEC;
  - the mismatch-policy constants STRICT_RESTART=1 and HOLD=0.
- One sub-module, seq_trig_timeout: a counter with load/clear and an expired flag, instantiated only under SEQ_TRIG_TIMEOUT_EN.

Test Plan:
- Default params, arm=1: apply valid words 3243f6a8..0734, 00112233..eeff, 0, 1 on consecutive cycles -> stage steps 1,2,3,4; trig and trig_pulse rise one cycle after the word 1; hit_count=1; trig_pulse low the following cycle.
- STRICT=1: send pattern0, pattern1, then 0xDEAD -> stage 2 then 0. Send pattern0, pattern0 -> stage 1, 1 (re-seed). Same sequence with STRICT=0 -> stage holds at 2.
- Valid gating: drive full sequence with data_valid=0, or with arm=0 -> stage stays 0 and trig=0. Drop arm after stage=2, pulse arm later -> resumes from 2.
- Sticky and clear: after trig=1 send more patterns -> no change. Assert trig_clr in the same cycle as a completing pattern3 -> trig=0, stage=0, trig_pulse=0. Repeat the full sequence 256 times with CNT_W=8 -> hit_count saturates at 255.
- Async reset: pull rst_n low mid-cycle at stage=3 -> all outputs 0 immediately, before the next clk edge.
- SEQ_TRIG_TIMEOUT_EN, TIMEOUT=8: pattern0, then 8 idle cycles -> stage returns to 0. With 7 idle cycles then pattern1 -> stage 2.
